// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, launches them onto an external ALU
// under a credit limit, and returns tagged results in acceptance order.
module alu_cmd_issuer #(
  parameter int DATA_W  = 16,
  parameter int FUN_W   = 4,
  parameter int OUT_W   = 32,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [FUN_W-1:0]  cmd_fun,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [OUT_W-1:0]  alu_out,
  output logic              res_valid,
  output logic [OUT_W-1:0]  res_out,
  output logic [TAG_W-1:0]  res_tag,
  input  logic              res_ready
);

  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int RDEPTH = ALU_LAT + 1;
  localparam int RPW    = $clog2(RDEPTH);
  localparam int RCW    = $clog2(RDEPTH + 1);
  localparam int OW     = $clog2(ALU_LAT + 2);
  localparam int EW     = 2 * DATA_W + FUN_W + TAG_W;
  localparam int RW     = OUT_W + TAG_W;

  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
  localparam logic [OW-1:0]  MAX_CREDIT = OW'(ALU_LAT + 1);
  localparam logic [RPW-1:0] RLAST      = RPW'(RDEPTH - 1);

  // command FIFO state
  logic [EW-1:0]     cmd_mem [DEPTH];
  logic [PW-1:0]     cmd_wr_ptr;
  logic [PW-1:0]     cmd_rd_ptr;
  logic [CW-1:0]     cmd_count;
  logic              ready_en;

  // head of the command FIFO
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [FUN_W-1:0]  head_fun;
  logic [TAG_W-1:0]  head_tag;

  // launch pipeline and credits
  logic [ALU_LAT-1:0] pipe_valid;
  logic [TAG_W-1:0]   pipe_tag [ALU_LAT];
  logic [OW-1:0]      outstanding;

  // result FIFO state
  logic [RW-1:0]     res_mem [RDEPTH];
  logic [RPW-1:0]    res_wr_ptr;
  logic [RPW-1:0]    res_rd_ptr;
  logic [RCW-1:0]    res_count;

  logic push;
  logic issue;
  logic res_push;
  logic res_consume;

  // cmd_ready only depends on registers, so upstream never sees a path from res_ready
  assign cmd_ready   = ready_en && (cmd_count != FULL_COUNT);
  assign push        = cmd_valid && cmd_ready;
  assign res_consume = res_valid && res_ready;
  // a slot freed by a same-cycle consume can be reused immediately for full throughput
  assign issue       = (cmd_count != '0) && ((outstanding < MAX_CREDIT) || res_consume);
  assign res_push    = pipe_valid[ALU_LAT-1];

  assign {head_a, head_b, head_fun, head_tag} = cmd_mem[cmd_rd_ptr];

  assign res_valid = (res_count != '0);
  assign {res_out, res_tag} = res_valid ? res_mem[res_rd_ptr] : '0;

  // hold cmd_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // command storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) cmd_mem[cmd_wr_ptr] <= {cmd_a, cmd_b, cmd_fun, cmd_tag};
  end

  // command FIFO pointers and occupancy; power-of-two depth wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (push)  cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
      if (issue) cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
      case ({push, issue})
        2'b10:   cmd_count <= cmd_count + CW'(1);
        2'b01:   cmd_count <= cmd_count - CW'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // operand launch registers hold the last issued command between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      b       <= '0;
      alu_fun <= '0;
    end else if (issue) begin
      a       <= head_a;
      b       <= head_b;
      alu_fun <= head_fun;
    end
  end

  // valid/tag shift register tracking commands inside the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < ALU_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_valid[0] <= issue;
      if (issue) pipe_tag[0] <= head_tag;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  // credit counter: launched results not yet taken by the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({issue, res_consume})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // result storage; credits keep writes away from the slot being presented
  always_ff @(posedge clk) begin
    if (res_push) res_mem[res_wr_ptr] <= {alu_out, pipe_tag[ALU_LAT-1]};
  end

  // result FIFO pointers and occupancy; depth need not be a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_count  <= '0;
    end else begin
      if (res_push)    res_wr_ptr <= (res_wr_ptr == RLAST) ? '0 : res_wr_ptr + RPW'(1);
      if (res_consume) res_rd_ptr <= (res_rd_ptr == RLAST) ? '0 : res_rd_ptr + RPW'(1);
      case ({res_push, res_consume})
        2'b10:   res_count <= res_count + RCW'(1);
        2'b01:   res_count <= res_count - RCW'(1);
        default: res_count <= res_count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench for alu_cmd_issuer with an adder stub ALU.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

  localparam int DATA_W  = 16;
  localparam int FUN_W   = 4;
  localparam int OUT_W   = 32;
  localparam int TAG_W   = 4;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [FUN_W-1:0]  cmd_fun;
  logic [TAG_W-1:0]  cmd_tag;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [FUN_W-1:0]  alu_fun;
  logic [OUT_W-1:0]  alu_out;
  logic              res_valid;
  logic [OUT_W-1:0]  res_out;
  logic [TAG_W-1:0]  res_tag;
  logic              res_ready;

  typedef struct packed {
    logic [OUT_W-1:0] out;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   done;

  logic             stall_hold = 1'b0;
  logic [OUT_W-1:0] held_out;
  logic [TAG_W-1:0] held_tag;
  exp_t             got_e;

  alu_cmd_issuer #(
    .DATA_W(DATA_W), .FUN_W(FUN_W), .OUT_W(OUT_W),
    .TAG_W(TAG_W), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun), .cmd_tag(cmd_tag),
    .a(a), .b(b), .alu_fun(alu_fun), .alu_out(alu_out),
    .res_valid(res_valid), .res_out(res_out), .res_tag(res_tag), .res_ready(res_ready)
  );

  // stub ALU: sum of the registered operands, valid one cycle after launch
  assign alu_out = OUT_W'(a) + OUT_W'(b);

  initial clk = 1'b0;
  // free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // offer one command until accepted; expected result is queued at the accepting edge
  task automatic apply_stimulus(input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                                input logic [FUN_W-1:0] vf, input logic [TAG_W-1:0] vt,
                                input logic [OUT_W-1:0] vexp);
    bit accepted;
    accepted  = 1'b0;
    cmd_a     = va;
    cmd_b     = vb;
    cmd_fun   = vf;
    cmd_tag   = vt;
    cmd_valid = 1'b1;
    for (int n = 0; n < 100 && !accepted; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1'b1;
        exp_q.push_back({vexp, vt});
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check_output("cmd_accept", accepted, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tagname);
    check_output({tagname, "_cmd_ready"}, cmd_ready, 0);
    check_output({tagname, "_res_valid"}, res_valid, 0);
    check_output({tagname, "_a"}, a, 0);
    check_output({tagname, "_b"}, b, 0);
    check_output({tagname, "_alu_fun"}, alu_fun, 0);
    check_output({tagname, "_res_out"}, res_out, 0);
    check_output({tagname, "_res_tag"}, res_tag, 0);
  endtask

  // monitor: pops the scoreboard on every result handshake and checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        check_output("stall_valid", res_valid, 1);
        check_output("stall_out", res_out, held_out);
        check_output("stall_tag", res_tag, held_tag);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_result_queue", exp_q.size(), 1);
        end else begin
          got_e = exp_q.pop_front();
          check_output("res_out", res_out, got_e.out);
          check_output("res_tag", res_tag, got_e.tag);
        end
        stall_hold = 1'b0;
      end else if (res_valid) begin
        stall_hold = 1'b1;
        held_out   = res_out;
        held_tag   = res_tag;
      end else begin
        stall_hold = 1'b0;
      end
    end
  end

  // watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // directed stimulus sequence
  initial begin
    int accepted_n;
    int run;
    int n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_fun   = '0;
    cmd_tag   = '0;
    res_ready = 1'b0;
    done      = 1'b0;

    // reset state and release behaviour
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    check_output("ready_after_first_edge", cmd_ready, 1);
    @(posedge clk);
    #1;

    // single command latency: 5+3 with tag 1
    $display("[TB] single command");
    res_ready = 1'b1;
    apply_stimulus(16'd5, 16'd3, 4'hA, 4'd1, 32'd8);
    @(negedge clk);
    check_output("lat_after_accept_valid", res_valid, 0);
    @(negedge clk);
    check_output("launch_a", a, 16'd5);
    check_output("launch_b", b, 16'd3);
    check_output("launch_fun", alu_fun, 4'hA);
    check_output("lat_after_launch_valid", res_valid, 0);
    @(negedge clk);
    check_output("lat_two_edges_valid", res_valid, 1);
    @(posedge clk);
    #1;
    drain("drain_single");

    // fill with consumer stalled: two launched, four queued, seventh refused
    $display("[TB] fill under backpressure");
    res_ready  = 1'b0;
    accepted_n = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      cmd_a     = DATA_W'(100 + accepted_n);
      cmd_b     = DATA_W'(2 * accepted_n);
      cmd_fun   = FUN_W'(accepted_n);
      cmd_tag   = TAG_W'(accepted_n);
      cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back({OUT_W'(100 + 3 * accepted_n), TAG_W'(accepted_n)});
        accepted_n++;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check_output("fill_accepts", accepted_n, 6);
    check_output("fill_ready_low", cmd_ready, 0);
    check_output("fill_res_valid", res_valid, 1);
    check_output("fill_last_launch_a", a, 16'd101);
    check_output("fill_last_launch_b", b, 16'd2);
    check_output("fill_pending", exp_q.size(), 6);

    // release backpressure: six results back to back
    $display("[TB] backpressure release");
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("release_run_valid", res_valid, 1);
    end
    @(posedge clk);
    #1;
    drain("drain_release");

    // streaming: one issue and one result per cycle, pointers wrap
    $display("[TB] stream of 16");
    res_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++)
          apply_stimulus(DATA_W'(i * 257), DATA_W'(1000 + i), FUN_W'(i), TAG_W'(i),
                         OUT_W'(i * 257 + 1000 + i));
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!res_valid && n < 50);
        run = 0;
        while (res_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
        check_output("stream_consecutive_results", run, 16);
      end
    join
    @(posedge clk);
    #1;
    drain("drain_stream");

    // randomised consumer stalls over 200 commands
    $display("[TB] random backpressure");
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [DATA_W-1:0] ra;
          logic [DATA_W-1:0] rb;
          ra = DATA_W'($urandom);
          rb = DATA_W'($urandom);
          apply_stimulus(ra, rb, FUN_W'(i), TAG_W'(i), OUT_W'(ra) + OUT_W'(rb));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          res_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    res_ready = 1'b1;
    drain("drain_random");

    // reset with three queued and two in flight
    $display("[TB] reset mid-operation");
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      apply_stimulus(DATA_W'(40 + i), DATA_W'(7), FUN_W'(i), TAG_W'(10 + i), OUT_W'(47 + i));
    check_output("pre_reset_valid", res_valid, 1);
    check_output("pre_reset_ready", cmd_ready, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("midreset_ready_before_edge", cmd_ready, 0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    apply_stimulus(16'd100, 16'd23, 4'h3, 4'd9, 32'd123);
    drain("drain_after_reset");
    idle(4);
    check_output("no_stale_result", res_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter DATA_W, 16, width of operands A/B.
REQ-002 Parameter FUN_W, 4, width of ALU function code.
REQ-003 Parameter OUT_W, 32, width of ALU_OUT.
REQ-004 Parameter TAG_W, 4, width of command tag.
REQ-005 Parameter DEPTH, 4, command FIFO depth (power of 2, >=2).
REQ-006 Parameter ALU_LAT, 1, ALU cycles from operand launch to valid ALU_OUT.
REQ-007 CLK  in  1  single clock; all state updates on rising edge.
REQ-008 RST  in  1  reset, asynchronous, active-low.
REQ-009 cmd_valid  in  1  command offered.
REQ-010 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at an edge.
REQ-011 cmd_A / cmd_B  in  DATA_W  operands; cmd_FUN in FUN_W; cmd_TAG in TAG_W.
REQ-012 A / B  out  DATA_W  operands to ALU; ALU_FUN out FUN_W.
REQ-013 ALU_OUT  in  OUT_W  ALU result.
REQ-014 res_valid  out  1  result available; res_OUT out OUT_W; res_TAG out TAG_W.
REQ-015 res_ready  in  1  result consumed when res_valid & res_ready at an edge.

Function
REQ-016 Command FIFO: DEPTH entries, registered, pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-017 cmd_ready = (count < DEPTH), registered-derived, no combinational path from res_ready or cmd_valid.
REQ-018 Push while full is ignored (cmd_ready low); push and issue-pop in same cycle leave count unchanged.
REQ-019 Credit counter outstanding = launched-not-yet-consumed results, range 0..ALU_LAT+1.
REQ-020 Issue condition: count > 0 and (outstanding < ALU_LAT+1 or result consumed this cycle).
REQ-021 On issue: FIFO head registered onto A, B, ALU_FUN (launch edge); head popped same edge.
REQ-022 A, B, ALU_FUN hold last launched values when not issuing.
REQ-023 Launch pipeline: ALU_LAT-stage shift register carrying valid + tag; stage 0 loaded at launch edge.
REQ-024 ALU_OUT sampled when pipeline last stage is valid; sampled value + tag written to result FIFO.
REQ-025 Result FIFO depth ALU_LAT+1; credits guarantee it never overflows; overflow is a design error.
REQ-026 res_valid = result FIFO non-empty; res_OUT/res_TAG = its head; stable while res_valid & !res_ready.
REQ-027 Ordering: results leave in command acceptance order; tags passed unmodified.
REQ-028 Throughput: with res_ready high and commands streaming, one issue per cycle, one result per cycle.
REQ-029 Latency: cmd accepted edge N -> launch edge N+1 (empty FIFO) -> res_valid high after edge N+1+ALU_LAT.
REQ-030 outstanding increments on issue, decrements on result consume; both same edge = unchanged.
REQ-031 Operands and function are not interpreted; block is function-agnostic.

Reset
REQ-032 RST low clears immediately: FIFO pointers/count, outstanding, pipeline valids, result FIFO.
REQ-033 During reset: cmd_ready=0, res_valid=0, A=0, B=0, ALU_FUN=0, res_OUT=0, res_TAG=0.
REQ-034 cmd_ready rises on the first rising edge after RST deasserts.
REQ-035 Reset mid-operation discards all queued and in-flight commands; no stale result after release.

Verification (bench uses stub ALU: ALU_OUT registered = A+B, ALU_LAT=1)
REQ-036 Single command A=5, B=3, TAG=1, res_ready=1 -> res_OUT=8, res_TAG=1 exactly 2 edges after accept.
REQ-037 Fill: res_ready=0, push 7 commands -> 2 launched (credits), 4 queued, cmd_ready=0 after 6th accept.
REQ-038 Backpressure release: from REQ-037 state raise res_ready -> 6 results in tag order, one per cycle.
REQ-039 Stream 16 commands, res_ready=1 -> 16 results on 16 consecutive cycles, tags 0..15 in order, FIFO pointers wrap.
REQ-040 Random res_ready toggling, 200 commands -> no loss, no duplication, res_OUT/res_TAG stable while stalled.
REQ-041 Assert RST with 3 queued, 2 in flight -> all outputs zero immediately; after release first result is from a new command.
